// File: rtl/parity_generator.sv
`default_nettype none
// ============================================================================
// Module   : parity_generator
// Brief    : AXI-Stream pass-through that appends one XOR parity beat per packet.
// Revision : 1.0
// ============================================================================
module parity_generator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ODD        = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  inclock,
  input  logic                  reset,
  input  logic                  axis_s_tvalid,
  input  logic [DATA_WIDTH-1:0] axis_s_tdata,
  input  logic                  axis_s_tlast,
  output logic                  axis_s_tready,
  output logic                  axis_m_tvalid,
  output logic [DATA_WIDTH-1:0] axis_m_tdata,
  output logic                  axis_m_tlast,
  input  logic                  axis_m_tready,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam logic [DATA_WIDTH-1:0] c_odd_mask = {DATA_WIDTH{(ODD != 0)}};

  typedef enum logic [0:0] {
    S_PASS   = 1'b0,
    S_APPEND = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic [CNT_WIDTH-1:0]  r_pkt_count;
  logic                  w_free;
  logic                  w_in_hs;
  logic                  w_parity_hs;

  // Output register can take a new beat if empty or draining this edge.
  assign w_free        = !r_m_tvalid || axis_m_tready;
  assign axis_s_tready = !reset && (r_state == S_PASS) && w_free;
  assign w_in_hs       = axis_s_tvalid && axis_s_tready;
  assign w_parity_hs   = r_m_tvalid && axis_m_tready && r_m_tlast;

  assign axis_m_tvalid = r_m_tvalid;
  assign axis_m_tdata  = r_m_tdata;
  assign axis_m_tlast  = r_m_tlast;
  assign pkt_count     = r_pkt_count;

  always_ff @(posedge inclock) begin
    if (reset) begin
      r_state <= S_PASS;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_PASS: begin
        if (w_in_hs && axis_s_tlast) begin
          w_state_next = S_APPEND;
        end
      end
      S_APPEND: begin
        if (w_free) begin
          w_state_next = S_PASS;
        end
      end
      default: w_state_next = S_PASS;
    endcase
  end

  always_ff @(posedge inclock) begin
    if (reset) begin
      r_m_tvalid  <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tlast   <= 1'b0;
      r_acc       <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_parity_hs) begin
        r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
      end
      case (r_state)
        S_PASS: begin
          if (w_in_hs) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= axis_s_tdata;
            r_m_tlast  <= 1'b0;
            r_acc      <= r_acc ^ axis_s_tdata;
          end else if (axis_m_tready) begin
            r_m_tvalid <= 1'b0;
          end
        end
        S_APPEND: begin
          // Accumulator already holds the last data beat of the packet.
          if (w_free) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= r_acc ^ c_odd_mask;
            r_m_tlast  <= 1'b1;
            r_acc      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_generator
// Brief    : Self-checking bench for parity_generator (even and odd instances).
// Revision : 1.0
// ============================================================================
module tb_parity_generator;

  localparam int DEPTH = 512;

  logic             inclock = 1'b0;
  logic             reset;
  logic             s_tvalid;
  logic [7:0]       s_tdata;
  logic             s_tlast;
  logic             m_tready;
  logic [1:0]       s_tready;
  logic [1:0]       m_tvalid;
  logic [1:0]       m_tlast;
  logic [1:0][7:0]  m_tdata;
  logic [1:0][15:0] pkt_count;

  parity_generator #(.DATA_WIDTH(8), .ODD(0), .CNT_WIDTH(16)) u_dut_even (
    .inclock(inclock), .reset(reset),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
    .axis_s_tready(s_tready[0]),
    .axis_m_tvalid(m_tvalid[0]), .axis_m_tdata(m_tdata[0]), .axis_m_tlast(m_tlast[0]),
    .axis_m_tready(m_tready), .pkt_count(pkt_count[0])
  );

  parity_generator #(.DATA_WIDTH(8), .ODD(1), .CNT_WIDTH(16)) u_dut_odd (
    .inclock(inclock), .reset(reset),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
    .axis_s_tready(s_tready[1]),
    .axis_m_tvalid(m_tvalid[1]), .axis_m_tdata(m_tdata[1]), .axis_m_tlast(m_tlast[1]),
    .axis_m_tready(m_tready), .pkt_count(pkt_count[1])
  );

  always #5 inclock = ~inclock;

  int cyc = 0;
  always @(posedge inclock) cyc <= cyc + 1;

  // Reference model: expected output stream as {last, data} in even form.
  logic [8:0]  exp_q [DEPTH];
  int          acc_edge [DEPTH];
  int          out_edge [DEPTH];
  logic [8:0]  obs [2][DEPTH];
  int          wr_idx;
  int          rd_idx [2];
  logic [7:0]  pkt_xor;
  logic [15:0] exp_cnt [2];
  int          pkts_sent;
  logic        prev_stall [2];
  logic [8:0]  prev_beat [2];
  logic        rand_ready;
  int          n_cmp;
  int          n_err;
  int          base;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic monitor();
    logic [8:0] e;
    logic [8:0] o;
    forever begin
      @(negedge inclock);
      if (reset) begin
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          o = {m_tlast[i], m_tdata[i]};
          check(i == 0 ? "pkt_count_even" : "pkt_count_odd", pkt_count[i], exp_cnt[i]);
          if (prev_stall[i]) begin
            check("hold_valid", m_tvalid[i], 1'b1);
            check("hold_beat", o, prev_beat[i]);
          end
          if (m_tvalid[i] && m_tready) begin
            if (rd_idx[i] >= wr_idx) begin
              check("extra_beat_valid", m_tvalid[i], 1'b0);
            end else begin
              e = exp_q[rd_idx[i]];
              if (i == 1 && e[8]) e[7:0] = e[7:0] ^ 8'hFF;
              check(i == 0 ? "beat_even" : "beat_odd", o, e);
              obs[i][rd_idx[i]] = o;
              if (i == 0) out_edge[rd_idx[0]] = cyc + 1;
              rd_idx[i]++;
              if (e[8]) exp_cnt[i]++;
            end
          end
          prev_stall[i] = m_tvalid[i] && !m_tready;
          prev_beat[i]  = o;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge inclock);
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    logic done;
    done     = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge inclock);
      if (s_tready[0]) begin
        done             = 1'b1;
        acc_edge[wr_idx] = cyc + 1;
        exp_q[wr_idx]    = {1'b0, d};
        wr_idx++;
        pkt_xor = pkt_xor ^ d;
        if (l) begin
          exp_q[wr_idx]    = {1'b1, pkt_xor};
          acc_edge[wr_idx] = 0;
          wr_idx++;
          pkt_xor = 8'h00;
          pkts_sent++;
        end
      end
      tick();
    end
    check("accept", done, 1'b1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int g = 0; g < 300 && !ok; g++) begin
      tick();
      ok = (rd_idx[0] == wr_idx) && (rd_idx[1] == wr_idx) && !m_tvalid[0] && !m_tvalid[1];
    end
    check("drain", ok, 1'b1);
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      check("rst_tvalid", m_tvalid[i], 1'b0);
      check("rst_tdata", m_tdata[i], 8'h00);
      check("rst_tlast", m_tlast[i], 1'b0);
      check("rst_pkt_count", pkt_count[i], 16'h0000);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
    m_tready = 1'b1; rand_ready = 1'b0;
    n_cmp = 0; n_err = 0; wr_idx = 0; rd_idx[0] = 0; rd_idx[1] = 0;
    pkt_xor = 8'h00; exp_cnt[0] = 16'h0; exp_cnt[1] = 16'h0; pkts_sent = 0;
    prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
    prev_beat[0] = 9'h0; prev_beat[1] = 9'h0;
    fork
      monitor();
    join_none

    // Reset state and first cycle after release
    tick(); tick();
    @(negedge inclock);
    check("tready_in_reset_even", s_tready[0], 1'b0);
    check("tready_in_reset_odd", s_tready[1], 1'b0);
    check_reset_outputs();
    tick();
    reset = 1'b0;
    @(negedge inclock);
    check("tready_after_reset", s_tready[0], 1'b1);
    tick();

    // Basic packet 01,02,04
    base = wr_idx;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h04, 1'b1);
    s_tvalid = 1'b0;
    drain();
    check("basic_d0", obs[0][base], 9'h001);
    check("basic_d2", obs[0][base+2], 9'h004);
    check("basic_par_even", obs[0][base+3], 9'h107);
    check("basic_par_odd", obs[1][base+3], 9'h1F8);
    check("basic_latency", out_edge[base], acc_edge[base] + 1);
    check("basic_consecutive", out_edge[base+3], out_edge[base] + 3);
    check("basic_count", pkt_count[0], 16'd1);

    // Single-beat packet
    base = wr_idx;
    send_beat(8'hA5, 1'b1);
    s_tvalid = 1'b0;
    drain();
    check("single_data", obs[0][base], 9'h0A5);
    check("single_par_even", obs[0][base+1], 9'h1A5);
    check("single_par_odd", obs[1][base+1], 9'h15A);

    // Back-to-back packets, source always valid
    base = wr_idx;
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b1);
    send_beat(8'h03, 1'b1);
    s_tvalid = 1'b0;
    drain();
    check("b2b_par1", obs[0][base+2], 9'h130);
    check("b2b_data2", obs[0][base+3], 9'h003);
    check("b2b_par2", obs[0][base+4], 9'h103);
    check("b2b_one_stall", acc_edge[base+3], acc_edge[base+1] + 2);
    check("b2b_accept_with_parity", out_edge[base+2], acc_edge[base+3]);
    check("b2b_consecutive", out_edge[base+4], out_edge[base] + 4);

    // Backpressure over a 16-beat packet
    base = wr_idx;
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(8'(i), i == 15);
    s_tvalid = 1'b0;
    rand_ready = 1'b0;
    m_tready = 1'b1;
    drain();
    check("bp_par_even", obs[0][base+16], 9'h100);
    check("bp_par_odd", obs[1][base+16], 9'h1FF);
    check("bp_count", pkt_count[0], 16'(pkts_sent));

    // Random packets, random backpressure and source gaps
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      automatic int len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        send_beat(8'($urandom), j == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          s_tvalid = 1'b0;
          tick();
        end
      end
    end
    s_tvalid = 1'b0;
    rand_ready = 1'b0;
    m_tready = 1'b1;
    drain();
    check("rand_count_even", pkt_count[0], 16'(pkts_sent));
    check("rand_count_odd", pkt_count[1], 16'(pkts_sent));

    // Reset mid-packet discards 0x22 held in output register
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    reset = 1'b1;
    wr_idx = rd_idx[0];
    pkt_xor = 8'h00;
    exp_cnt[0] = 16'h0;
    exp_cnt[1] = 16'h0;
    pkts_sent = 0;
    @(negedge inclock);
    check("tready_mid_reset", s_tready[0], 1'b0);
    tick();
    reset = 1'b0;
    @(negedge inclock);
    check_reset_outputs();
    m_tready = 1'b1;
    tick();
    base = wr_idx;
    send_beat(8'h05, 1'b1);
    s_tvalid = 1'b0;
    drain();
    check("post_reset_data", obs[0][base], 9'h005);
    check("post_reset_par", obs[0][base+1], 9'h105);
    check("post_reset_count", pkt_count[0], 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
